// File: rtl/uart8_mem_reader_if.sv
// Bundles the command, Avalon-MM read and TX byte-stream signals of uart8_mem_reader.
// The master modport is the reader's view; the slave modport is the surrounding
// system (command source, memory and transmitter).
interface uart8_mem_reader_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 12
);
    logic              cmd_valid;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic              avm_clken;
    logic [31:0]       avm_readdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_len,
        output busy,
        output done,
        output avm_address,
        output avm_chipselect,
        output avm_write,
        output avm_byteenable,
        output avm_clken,
        input  avm_readdata,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        output cmd_valid,
        output cmd_addr,
        output cmd_len,
        input  busy,
        input  done,
        input  avm_address,
        input  avm_chipselect,
        input  avm_write,
        input  avm_byteenable,
        input  avm_clken,
        output avm_readdata,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart8_mem_reader.sv
// Avalon-MM read initiator that drains a region of 32-bit memory into a byte stream.
// One word is read at a time (no prefetch); each word is unpacked little-endian onto
// a valid/ready byte port. A partial final word emits only its low-order bytes.
module uart8_mem_reader #(
    parameter int ADDR_W       = 10,
    parameter int LEN_W        = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    uart8_mem_reader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } state_t;

    // Index of the final WAIT cycle, where readdata is valid and captured.
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic [1:0]        r_index;
    logic [1:0]        r_latCnt;
    logic [31:0]       r_word;

    logic              w_latDone;
    logic              w_handshake;
    logic              w_lastByte;
    logic [7:0]        w_byte;

    assign w_latDone   = (r_latCnt == LAT_LAST);
    assign w_handshake = (r_state == SEND) && bus.tx_ready;
    assign w_lastByte  = (r_remaining == LEN_W'(1));

    // Fixed Avalon controls: read-only, all byte lanes, clock always enabled.
    assign bus.avm_write      = 1'b0;
    assign bus.avm_byteenable = 4'hF;
    assign bus.avm_clken      = 1'b1;
    assign bus.avm_address    = r_addr;
    assign bus.tx_data        = w_byte;

    // Select the current byte of the captured word, byte 0 being the least significant.
    always_comb begin
        w_byte = r_word[7:0];
        case (r_index)
            2'd0:    w_byte = r_word[7:0];
            2'd1:    w_byte = r_word[15:8];
            2'd2:    w_byte = r_word[23:16];
            2'd3:    w_byte = r_word[31:24];
            default: w_byte = r_word[7:0];
        endcase
    end

    // State register; async reset drops every strobe immediately, aborting any transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        w_nextState        = r_state;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.avm_chipselect = 1'b0;
        bus.tx_valid       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_nextState = (bus.cmd_len != '0) ? READ : FIN;
                end
            end
            READ: begin
                bus.busy           = 1'b1;
                bus.avm_chipselect = 1'b1;
                w_nextState        = WAIT;
            end
            WAIT: begin
                bus.busy = 1'b1;
                if (w_latDone) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                bus.busy     = 1'b1;
                bus.tx_valid = 1'b1;
                if (w_handshake) begin
                    if (w_lastByte) begin
                        w_nextState = FIN;
                    end else if (r_index == 2'd3) begin
                        w_nextState = READ;
                    end
                end
            end
            FIN: begin
                bus.busy    = 1'b1;
                bus.done    = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: command latch, latency count, word capture and byte/length bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_index     <= 2'd0;
            r_latCnt    <= 2'd0;
            r_word      <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_addr      <= bus.cmd_addr;
                        r_remaining <= bus.cmd_len;
                        r_index     <= 2'd0;
                    end
                end
                READ: begin
                    r_latCnt <= 2'd0;
                end
                WAIT: begin
                    if (w_latDone) begin
                        r_word  <= bus.avm_readdata;
                        r_index <= 2'd0;
                    end else begin
                        r_latCnt <= r_latCnt + 2'd1;
                    end
                end
                SEND: begin
                    if (w_handshake) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_index     <= r_index + 2'd1;
                        if (r_index == 2'd3 && !w_lastByte) begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart8_mem_reader.sv
// Self-checking bench for uart8_mem_reader: directed commands push expected bytes and
// read addresses into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_uart8_mem_reader;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 12;
    localparam int RL     = 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    uart8_mem_reader_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    uart8_mem_reader #(
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W),
        .READ_LATENCY(RL)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [31:0] mem [0:1023];

    logic [7:0]        expBytes [$];
    logic [ADDR_W-1:0] expAddr  [$];

    int totalChecks = 0;
    int passCount   = 0;
    int cycleCount  = 0;
    int hsCount     = 0;
    int doneCount   = 0;
    int busyCycles  = 0;
    int validCycles = 0;
    int lastHsCycle = 0;
    int doneStart   = 0;
    int readyMode   = 0;
    bit checkDoneTiming = 1'b0;

    // One comparison: counts it, prints a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // A check that failed outright (unexpected event or expired bound).
    task automatic reportFail(input string name, input logic [31:0] act);
        totalChecks++;
        $display("[TB] FAIL %s: got %h, expected no such event", name, act);
    endtask

    // Memory slave with READ_LATENCY 1; outside a read it returns junk so mistimed capture shows.
    always @(posedge clk) begin
        if (bus.avm_chipselect && !bus.avm_write)
            bus.avm_readdata <= mem[bus.avm_address];
        else
            bus.avm_readdata <= 32'hDEADBEEF;
    end

    // Transmitter ready driver: always ready, or about 30 percent stalls.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (readyMode == 1)
                bus.tx_ready = ($urandom_range(0, 99) >= 30);
            else
                bus.tx_ready = 1'b1;
        end
    end

    // Monitor: compares reads, bytes, stall stability and done timing against the queues.
    initial begin
        bit          prevStall;
        logic [7:0]  prevData;
        logic [7:0]  eb;
        logic [ADDR_W-1:0] ea;
        prevStall = 1'b0;
        prevData  = 8'h00;
        forever begin
            @(negedge clk);
            cycleCount++;
            if (!reset_n) begin
                prevStall = 1'b0;
            end else begin
                if (bus.busy) busyCycles++;
                if (bus.tx_valid) validCycles++;
                if (prevStall) begin
                    checkOutput("stall_valid", {31'd0, bus.tx_valid}, 32'd1);
                    checkOutput("stall_data", {24'd0, bus.tx_data}, {24'd0, prevData});
                end
                if (bus.avm_chipselect) begin
                    if (expAddr.size() == 0) begin
                        reportFail("read_unexpected", 32'(bus.avm_address));
                    end else begin
                        ea = expAddr.pop_front();
                        checkOutput("read_addr", 32'(bus.avm_address), 32'(ea));
                    end
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    hsCount++;
                    lastHsCycle = cycleCount;
                    if (expBytes.size() == 0) begin
                        reportFail("byte_unexpected", {24'd0, bus.tx_data});
                    end else begin
                        eb = expBytes.pop_front();
                        checkOutput("tx_byte", {24'd0, bus.tx_data}, {24'd0, eb});
                    end
                end
                if (bus.done) begin
                    doneCount++;
                    if (checkDoneTiming)
                        checkOutput("done_latency", 32'(cycleCount - lastHsCycle), 32'd1);
                end
                prevStall = bus.tx_valid && !bus.tx_ready;
                prevData  = bus.tx_data;
            end
        end
    end

    // Issue one command for a single cycle while the DUT is idle.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        doneStart = doneCount;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
    endtask

    // Bounded wait for the done pulse of the current command.
    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (doneCount > doneStart) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) reportFail({name, "_done_timeout"}, 32'(doneCount));
    endtask

    // After a transfer every expected byte and read must have been consumed.
    task automatic checkEmpty(input string name);
        @(negedge clk);
        checkOutput({name, "_bytes_left"}, 32'(expBytes.size()), 32'd0);
        checkOutput({name, "_reads_left"}, 32'(expAddr.size()), 32'd0);
    endtask

    initial begin
        int base;
        int busyBase;
        int validBase;
        bit reached;

        #500000;
        $display("[TB] FAIL global_timeout: got %0d cycles, expected completion", cycleCount);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int base;
        int busyBase;
        int validBase;
        bit reached;

        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hF0F00000 | 32'(i);
        mem[5]    = 32'h44332211;
        mem[6]    = 32'h88776655;
        mem[7]    = 32'hCCBBAA99;
        mem[8]    = 32'h00FFEEDD;
        mem[1023] = 32'hDDCCBBAA;
        mem[0]    = 32'h04030201;

        // Reset values while reset_n is held low.
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_busy",       {31'd0, bus.busy},           32'd0);
        checkOutput("rst_done",       {31'd0, bus.done},           32'd0);
        checkOutput("rst_tx_valid",   {31'd0, bus.tx_valid},       32'd0);
        checkOutput("rst_chipselect", {31'd0, bus.avm_chipselect}, 32'd0);
        checkOutput("rst_address",    32'(bus.avm_address),        32'd0);
        checkOutput("rst_tx_data",    {24'd0, bus.tx_data},        32'd0);
        checkOutput("rst_write",      {31'd0, bus.avm_write},      32'd0);
        checkOutput("rst_byteenable", {28'd0, bus.avm_byteenable}, 32'hF);
        checkOutput("rst_clken",      {31'd0, bus.avm_clken},      32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] two full words from address 5");
        checkDoneTiming = 1'b1;
        expAddr.push_back(10'd5);
        expAddr.push_back(10'd6);
        foreach (mem[5][b]) begin end
        expBytes.push_back(8'h11); expBytes.push_back(8'h22);
        expBytes.push_back(8'h33); expBytes.push_back(8'h44);
        expBytes.push_back(8'h55); expBytes.push_back(8'h66);
        expBytes.push_back(8'h77); expBytes.push_back(8'h88);
        applyStimulus(10'd5, 12'd8);
        waitDone("t1");
        checkEmpty("t1");

        $display("[TB] partial word, three bytes");
        expAddr.push_back(10'd5);
        expBytes.push_back(8'h11); expBytes.push_back(8'h22); expBytes.push_back(8'h33);
        applyStimulus(10'd5, 12'd3);
        waitDone("t2");
        checkEmpty("t2");

        $display("[TB] zero-length command");
        checkDoneTiming = 1'b0;
        busyBase  = busyCycles;
        validBase = validCycles;
        base      = doneCount;
        applyStimulus(10'd5, 12'd0);
        waitDone("t3");
        repeat (3) @(negedge clk);
        checkOutput("t3_busy_cycles",  32'(busyCycles - busyBase),   32'd1);
        checkOutput("t3_valid_cycles", 32'(validCycles - validBase), 32'd0);
        checkOutput("t3_done_pulses",  32'(doneCount - base),        32'd1);
        checkEmpty("t3");

        $display("[TB] address wrap 1023 -> 0");
        checkDoneTiming = 1'b1;
        expAddr.push_back(10'd1023);
        expAddr.push_back(10'd0);
        expBytes.push_back(8'hAA); expBytes.push_back(8'hBB);
        expBytes.push_back(8'hCC); expBytes.push_back(8'hDD);
        expBytes.push_back(8'h01); expBytes.push_back(8'h02);
        expBytes.push_back(8'h03); expBytes.push_back(8'h04);
        applyStimulus(10'd1023, 12'd8);
        waitDone("t4");
        checkEmpty("t4");

        $display("[TB] sixteen bytes with random stalls and a stray command");
        readyMode = 1;
        for (int w = 5; w <= 8; w++) expAddr.push_back(10'(w));
        expBytes.push_back(8'h11); expBytes.push_back(8'h22);
        expBytes.push_back(8'h33); expBytes.push_back(8'h44);
        expBytes.push_back(8'h55); expBytes.push_back(8'h66);
        expBytes.push_back(8'h77); expBytes.push_back(8'h88);
        expBytes.push_back(8'h99); expBytes.push_back(8'hAA);
        expBytes.push_back(8'hBB); expBytes.push_back(8'hCC);
        expBytes.push_back(8'hDD); expBytes.push_back(8'hEE);
        expBytes.push_back(8'hFF); expBytes.push_back(8'h00);
        applyStimulus(10'd5, 12'd16);
        repeat (10) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 10'd100;
        bus.cmd_len   = 12'd1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        waitDone("t5");
        readyMode = 0;
        checkEmpty("t5");
        base = doneCount;
        repeat (5) @(negedge clk);
        checkOutput("t5_no_extra_done", 32'(doneCount - base), 32'd0);

        $display("[TB] reset during third byte, then recovery");
        expAddr.push_back(10'd5);
        expBytes.push_back(8'h11); expBytes.push_back(8'h22);
        base = hsCount;
        applyStimulus(10'd5, 12'd8);
        reached = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (hsCount == base + 2) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) reportFail("t6_second_byte_timeout", 32'(hsCount - base));
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_tx_valid",   {31'd0, bus.tx_valid},       32'd0);
        checkOutput("t6_rst_busy",       {31'd0, bus.busy},           32'd0);
        checkOutput("t6_rst_chipselect", {31'd0, bus.avm_chipselect}, 32'd0);
        repeat (3) @(posedge clk);
        checkOutput("t6_no_done", 32'(doneCount - doneStart), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        checkEmpty("t6a");
        expAddr.push_back(10'd5);
        expBytes.push_back(8'h11); expBytes.push_back(8'h22);
        expBytes.push_back(8'h33); expBytes.push_back(8'h44);
        applyStimulus(10'd5, 12'd4);
        waitDone("t6");
        checkEmpty("t6b");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule

// File: doc/uart8_mem_reader.md
Name: uart8_mem_reader

Overview:
- Avalon-MM read initiator that drains a region of the 32-bit on-chip memory into a byte stream for the UART8 transmitter.
- A command (word start address, byte length) launches single-word reads of the memory slave, fixed read latency, no waitrequest.
- Each word is unpacked little-endian (byte 0 = readdata[7:0]) onto a valid/ready byte port feeding the TX path.

Parameters:
ADDR_W, 10, memory word-address width (1024 words).
LEN_W, 12, byte-length field width; maximum length 4095 bytes.
READ_LATENCY, 1, cycles from address presentation to valid readdata (1 or 2).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe; sampled only in IDLE
cmd_addr  in  ADDR_W  starting word address
cmd_len  in  LEN_W  number of bytes to send
busy  out  1  high from command accept until done
done  out  1  one-cycle pulse when the transfer completes
avm_address  out  ADDR_W  memory word address
avm_chipselect  out  1  read strobe, one cycle per word
avm_write  out  1  tied 0
avm_byteenable  out  4  tied 4'hF
avm_clken  out  1  tied 1
avm_readdata  in  32  memory read data
tx_data  out  8  byte to transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready

Behaviour:
- Reset (async, reset_n low): state IDLE. busy, done, avm_chipselect, tx_valid = 0. avm_address, tx_data = 0. Internal counters = 0.
- States: IDLE, READ, WAIT, SEND, FIN.
- IDLE: cmd_valid=1 latches cmd_addr and cmd_len, sets busy.
  - len != 0 -> READ.
  - len == 0 -> FIN (no memory access).
  - cmd_valid is ignored in every state other than IDLE.
- READ (1 cycle): avm_chipselect=1, avm_address=current word address. Then WAIT.
- WAIT: count READ_LATENCY cycles after the READ cycle. avm_readdata is captured into the word register on the last WAIT cycle. Then SEND, with byte index 0.
- SEND:
  - tx_valid=1, tx_data = word byte[index]. tx_data holds stable while tx_valid & !tx_ready.
  - On handshake: remaining bytes decrement, index increments.
  - remaining reaches 0 -> FIN, tx_valid drops the next cycle.
  - index 3 handshaken with bytes remaining -> address+1 -> READ.
- Partial last word: only the remaining 1-3 low-order bytes are emitted; upper bytes are discarded.
- Address wrap: word address increments modulo 2^ADDR_W (1023 -> 0), with no error.
- FIN (1 cycle): done=1, busy=0 on the following cycle -> IDLE. A new cmd_valid is accepted no earlier than the cycle after done.
- Throughput: per word, 1 + READ_LATENCY overhead cycles plus 4 handshake cycles, with tx_ready constantly high. No read prefetch.
- Reset mid-transfer: immediate return to IDLE. The in-flight byte is dropped, tx_valid goes low asynchronously, and no done pulse is issued.
- avm_write is never asserted. Any readdata outside the capture cycle is ignored.

Test Plan:
- Memory preloaded word 5 = 32'h44332211, word 6 = 32'h88776655; cmd addr=5 len=8, tx_ready=1 -> tx bytes 11,22,33,44,55,66,77,88; two chipselect pulses at addresses 5 and 6; done pulse 1 cycle after the last handshake.
- cmd addr=5 len=3 -> bytes 11,22,33 only; exactly one read; done asserted; byte 44 never presented.
- cmd len=0 -> no chipselect and no tx_valid; busy high for 1 cycle, then a done pulse.
- cmd addr=1023 len=8, word 1023 = 32'hDDCCBBAA, word 0 = 32'h04030201 -> bytes AA,BB,CC,DD,01,02,03,04; second read at address 0.
- Random tx_ready stalls (30% low) on a len=16 transfer -> tx_data stable while stalled, byte order unchanged, no duplicated or dropped bytes; cmd_valid pulsed mid-transfer is ignored.
- reset_n asserted during SEND of byte 2 -> tx_valid, busy, chipselect = 0 immediately; no done pulse; a subsequent cmd addr=5 len=4 completes correctly (11,22,33,44).
